// File: rtl/uart_tx_serializer.sv
// UART transmit path: byte FIFO feeding an 8N1 serializer with LSR THRE/TEMT status.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_serializer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          lsr_thre,
    output logic                          lsr_temt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [7:0]           shreg;
    logic [2:0]           bit_cnt;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [DIV_WIDTH-1:0] period;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    logic                 push;
    logic                 pop;
    logic                 launch;
    logic                 go_idle;
    logic                 bit_done;
    logic [CW-1:0]        count_next;
    logic [DIV_WIDTH-1:0] p_eff;

    // A new frame may start from IDLE or straight out of a finished stop bit.
    assign push       = wr_valid && wr_ready;
    assign bit_done   = (baud_cnt == '0);
    assign launch     = (state == IDLE) || ((state == STOP) && bit_done);
    assign pop        = launch && (fifo_count != '0);
    assign go_idle    = launch && (fifo_count == '0);
    assign count_next = fifo_count + CW'(push) - CW'(pop);
    assign p_eff      = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;

    // FIFO storage needs no reset; only the pointers define occupancy.
    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            wr_ready   <= 1'b1;
            lsr_thre   <= 1'b1;
            lsr_temt   <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            period     <= DIV_WIDTH'(1);
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            fifo_count <= count_next;
            wr_ready   <= (count_next != CW'(FIFO_DEPTH));
            lsr_thre   <= (count_next == '0);
            tx_busy    <= !go_idle;
            lsr_temt   <= (count_next == '0) && go_idle;

            if (pop) begin
                state    <= START;
                txd      <= 1'b0;
                shreg    <= mem[rptr];
                period   <= p_eff;
                baud_cnt <= p_eff - DIV_WIDTH'(1);
                bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                parity   <= ^mem[rptr];
`endif
            end else if (go_idle) begin
                state <= IDLE;
                txd   <= 1'b1;
            end else if (!bit_done) begin
                baud_cnt <= baud_cnt - DIV_WIDTH'(1);
            end else begin
                // Bit period elapsed: advance to the next bit of the frame.
                baud_cnt <= period - DIV_WIDTH'(1);
                case (state)
                    START: begin
                        state <= DATA;
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= parity;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'(1);
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
`endif
                    default: begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: per-cycle comparison against a queue-based line model plus literal frame checks.
module tb_uart_tx_serializer;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned DIV_WIDTH  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic                 pclk;
    logic                 presetn;
    logic                 wr_valid;
    logic [7:0]           wr_data;
    logic                 wr_ready;
    logic [DIV_WIDTH-1:0] baud_div;
    logic                 txd;
    logic                 tx_busy;
    logic [3:0]           fifo_count;
    logic                 lsr_thre;
    logic                 lsr_temt;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_serializer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .baud_div   (baud_div),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .lsr_thre   (lsr_thre),
        .lsr_temt   (lsr_temt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: bytes wait in a queue; when the line has no pending frame bits,
    // the oldest byte expands into its full per-cycle waveform.
    logic [7:0] mq[$];
    bit         wave[$];
    logic       exp_txd   = 1'b1;
    logic       exp_busy  = 1'b0;
    int         exp_count = 0;
    bit         m_rdy;
    logic [7:0] m_byte;
    int         m_per;
    bit         m_v;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mq.delete();
            wave.delete();
            exp_txd   <= 1'b1;
            exp_busy  <= 1'b0;
            exp_count <= 0;
        end else begin
            m_rdy = (mq.size() != FIFO_DEPTH);
            if (wave.size() == 0 && mq.size() != 0) begin
                m_byte = mq.pop_front();
                m_per  = (baud_div == 0) ? 1 : int'(baud_div);
                for (int i = 0; i < FRAME_BITS; i++) begin
                    if (i == 0)                m_v = 1'b0;
                    else if (i <= 8)           m_v = m_byte[i-1];
                    else if (i < FRAME_BITS-1) m_v = ^m_byte;
                    else                       m_v = 1'b1;
                    for (int j = 0; j < m_per; j++) wave.push_back(m_v);
                end
            end
            if (wr_valid && m_rdy) mq.push_back(wr_data);
            if (wave.size() != 0) begin
                exp_txd  <= wave.pop_front();
                exp_busy <= 1'b1;
            end else begin
                exp_txd  <= 1'b1;
                exp_busy <= 1'b0;
            end
            exp_count <= mq.size();
        end
    end

    always @(negedge pclk) begin
        check("txd",        64'(txd),        64'(exp_txd));
        check("tx_busy",    64'(tx_busy),    64'(exp_busy));
        check("fifo_count", 64'(fifo_count), 64'(exp_count));
        check("wr_ready",   64'(wr_ready),   64'(exp_count != FIFO_DEPTH));
        check("lsr_thre",   64'(lsr_thre),   64'(exp_count == 0));
        check("lsr_temt",   64'(lsr_temt),   64'(exp_count == 0 && !exp_busy));
    end

    task automatic push_one(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge pclk);
        wr_valid = 1'b0;
        check("line_high_before_start", 64'(txd), 64'd1);
        @(negedge pclk);
    endtask

    task automatic capture(input int n, output logic [63:0] v);
        v = '0;
        for (int k = 0; k < n; k++) begin
            v[k] = txd;
            @(negedge pclk);
        end
    endtask

    logic [63:0] cap;
    logic [19:0] even_bits;
    bit          saw_full;
    bit          stayed_high;

    initial begin
        presetn  = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        baud_div = 16'd4;
        #2 presetn = 1'b0;
        #1;
        check("rst_txd",      64'(txd),        64'd1);
        check("rst_busy",     64'(tx_busy),    64'd0);
        check("rst_count",    64'(fifo_count), 64'd0);
        check("rst_ready",    64'(wr_ready),   64'd1);
        check("rst_thre",     64'(lsr_thre),   64'd1);
        check("rst_temt",     64'(lsr_temt),   64'd1);
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        repeat (2) @(negedge pclk);

        // Single byte 0x55 at P=4
        baud_div = 16'd4;
        push_one(8'h55);
        capture(40, cap);
        check("frame_55_p4", cap, 64'hF0F0F0F0F0);
        check("temt_after_55", 64'(lsr_temt), 64'd1);
        repeat (2) @(negedge pclk);

        // Back-to-back 0xA5, 0x3C at P=2
        baud_div = 16'd2;
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(negedge pclk);
        wr_data  = 8'h3C;
        @(negedge pclk);
        wr_valid = 1'b0;
        capture(40, cap);
        for (int i = 0; i < 20; i++) even_bits[i] = cap[2*i];
        check("frames_a5_3c_p2", 64'(even_bits), 64'h9E34A);
        check("temt_after_b2b", 64'(lsr_temt), 64'd1);
        repeat (2) @(negedge pclk);

        // Divisor zero behaves as one cycle per bit
        baud_div = 16'd0;
        push_one(8'hFF);
        capture(10, cap);
        check("frame_ff_div0", cap, 64'h3FE);
        check("temt_after_ff", 64'(lsr_temt), 64'd1);
        repeat (2) @(negedge pclk);

        // 0x07 at P=1 (parity bit 1 when enabled)
        baud_div = 16'd1;
        push_one(8'h07);
        capture(FRAME_BITS, cap);
`ifdef UART_TX_PARITY_EN
        check("frame_07_parity", cap, 64'h60E);
`else
        check("frame_07_plain", cap, 64'h20E);
`endif
        repeat (2) @(negedge pclk);

        // Streaming pushes faster than drain: FIFO fills and wraps
        baud_div = 16'd0;
        saw_full = 1'b0;
        for (int c = 0; c < 24; c++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(c + 48);
            @(negedge pclk);
            if (wr_ready == 1'b0) saw_full = 1'b1;
        end
        wr_valid = 1'b0;
        check("stream_reached_full", 64'(saw_full), 64'd1);
        repeat (140) @(negedge pclk);
        check("stream_drained_count", 64'(fifo_count), 64'd0);
        check("stream_drained_temt",  64'(lsr_temt),   64'd1);

        // Stalled serializer: nine pushes fill FIFO, tenth is refused
        baud_div = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            @(negedge pclk);
        end
        wr_valid = 1'b0;
        check("full_count", 64'(fifo_count), 64'd8);
        check("full_ready", 64'(wr_ready),   64'd0);
        check("full_thre",  64'(lsr_thre),   64'd0);
        check("full_busy",  64'(tx_busy),    64'd1);
        check("full_txd",   64'(txd),        64'd0);
        #2 presetn = 1'b0;
        #1;
        check("full_rst_count", 64'(fifo_count), 64'd0);
        @(negedge pclk);
        presetn = 1'b1;
        repeat (2) @(negedge pclk);

        // Reset during data bit 3 of 0x00 with another byte queued
        baud_div = 16'd4;
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        @(negedge pclk);
        wr_data  = 8'h01;
        @(negedge pclk);
        wr_valid = 1'b0;
        repeat (17) @(negedge pclk);
        check("mid_bit3_low", 64'(txd), 64'd0);
        #2 presetn = 1'b0;
        #1;
        check("mid_rst_txd",   64'(txd),        64'd1);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_thre",  64'(lsr_thre),   64'd1);
        check("mid_rst_temt",  64'(lsr_temt),   64'd1);
        check("mid_rst_busy",  64'(tx_busy),    64'd0);
        @(negedge pclk);
        presetn = 1'b1;
        stayed_high = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge pclk);
            if (txd !== 1'b1) stayed_high = 1'b0;
        end
        check("no_resume_after_reset", 64'(stayed_high), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream consumer of the APB UART register stage.
- Accepts bytes written to the THR (0x10000000) and buffers them in a small FIFO.
- Serializes each byte onto a physical 8N1 TXD line at a programmable bit period.
- Produces the LSR transmit status bits (THRE = bit 5, TEMT = bit 6) that the register stage returns on LSR reads (0x10000005).

Parameters:
- FIFO_DEPTH, 8, number of byte entries; power of two, at least 2.
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- pclk  input  1  system clock, rising edge
- presetn  input  1  asynchronous active-low reset
- wr_valid  input  1  register stage presents a byte to enqueue
- wr_data  input  8  byte to transmit
- wr_ready  output  1  FIFO can accept; a push occurs when wr_valid && wr_ready
- baud_div  input  DIV_WIDTH  pclk cycles per serial bit; 0 treated as 1
- txd  output  1  serial output, idle high
- tx_busy  output  1  serializer is not IDLE
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries
- lsr_thre  output  1  FIFO empty
- lsr_temt  output  1  FIFO empty and serializer IDLE

Behaviour:
- Reset (asynchronous, presetn low):
  - txd=1, tx_busy=0, fifo_count=0, lsr_thre=1, lsr_temt=1, wr_ready=1.
  - FSM enters IDLE; FIFO pointers and bit/baud counters cleared.
- Reset mid-frame: txd returns high immediately; queued bytes are discarded; no partial-frame resume after release.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - wr_ready = (fifo_count != FIFO_DEPTH), purely registered-state based; no full bypass.
  - Push and pop in the same cycle: fifo_count unchanged, both pointers advance.
  - Push while full: ignored (wr_ready=0 already); no overwrite.
- Serializer FSM states: IDLE, START, DATA, STOP (PARITY when feature enabled).
  - IDLE: if FIFO non-empty, pop head into shift register at next edge, latch baud_div (0→1) as bit period P, enter START, drive txd=0.
  - Each state holds its bit for exactly P cycles, timed by a down-counter reloaded to P-1.
  - DATA: 8 bits, LSB first; shift right each bit period.
  - STOP: txd=1 for P cycles. Then, if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - baud_div changes take effect only at the next frame start.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE drives txd low after edge N+1.
- Frame length: 10·P cycles from txd falling to the end of the stop bit.
- Status (all registered):
  - tx_busy = state != IDLE.
  - lsr_thre = fifo_count==0.
  - lsr_temt = lsr_thre && !tx_busy.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for P cycles; frame length 11·P.
- Undefined: no PARITY state, plain 8N1, 10·P cycles.

Test Plan:
- Single byte: baud_div=4, push 0x55 → txd low 1 cycle after push visible, then bits 1,0,1,0,1,0,1,0 (LSB first), each 4 cycles, then stop high 4 cycles; lsr_temt returns 1 after 40 cycles.
- FIFO full: push 9 bytes 0x00..0x08 with FSM stalled (baud_div=0xFFFF) → first byte popped into shifter, FIFO holds 0x01..0x08, wr_ready=0, fifo_count=8; next push is blocked.
- Back-to-back: baud_div=2, push 0xA5 and 0x3C → second start bit begins the cycle after the first stop bit ends; total 40 cycles with no idle gap.
- Divisor zero: baud_div=0, push 0xFF → 1 cycle per bit; start low 1 cycle, then txd high for 9 cycles.
- Reset mid-frame: push 0x00, assert presetn during bit 3 → txd=1 asynchronously, fifo_count=0, lsr_thre=1, lsr_temt=1; after release no further transitions on txd.
- Parity (UART_TX_PARITY_EN): push 0x07, baud_div=1 → bit 9 = 1 (three ones), then stop; frame is 11 cycles.
